mipi_rx_packet_controller: RTL and testbench

- Sequences CSI-2 packet reception downstream of mipi_rx_lane_aligner.
- Consumes the aligned 4-lane byte stream and parses the packet header.
- Tracks long-packet payload/CRC length and emits byte-enabled payload words plus frame/line event pulses.
- Drives packet_done_o back to the aligner/PHY control to terminate HS reception at end of packet.

---
 rtl/mipi_csi_pkg.sv | 39 +++
 rtl/mipi_csi_header_ecc.sv | 30 +++
 rtl/mipi_rx_packet_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_mipi_rx_packet_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data-type codes, header field offsets,
// packet controller state encoding and the tail-word byte-enable helper.
package mipi_csi_pkg;

    // Short-packet data types that produce frame/line event pulses.
    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LINE_START  = 6'h02;
    localparam logic [5:0] DT_LINE_END    = 6'h03;
    // Anything at or below this code is a short packet.
    localparam logic [5:0] DT_SHORT_MAX   = 6'h0F;

    // Packet header layout inside the aligned 32-bit word.
    localparam int HDR_DI_LSB  = 0;
    localparam int HDR_WC_LSB  = 8;
    localparam int HDR_ECC_LSB = 24;

    // Number of CRC bytes trailing every long packet.
    localparam logic [16:0] CRC_BYTES = 17'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DONE    = 2'd2
    } rx_state_e;

    // Byte enables for a word carrying n (1..3) payload bytes; 0 means a full word.
    function automatic logic [3:0] tail_be(input logic [1:0] n);
        logic [3:0] be;
        case (n)
            2'd1:    be = 4'b0001;
            2'd2:    be = 4'b0011;
            2'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// Combinational CSI-2 packet header ECC generator: 6 Hamming parity bits
// over the 24 header bits (DI + WC). Detection use only.
module mipi_csi_header_ecc (
    input  logic [23:0] hdr_i,
    output logic [5:0]  ecc_o
);

    // Parity equations from the CSI-2 header ECC definition.
    always_comb begin
        ecc_o[0] = hdr_i[0]  ^ hdr_i[1]  ^ hdr_i[2]  ^ hdr_i[4]  ^ hdr_i[5]  ^ hdr_i[7]  ^
                   hdr_i[10] ^ hdr_i[11] ^ hdr_i[13] ^ hdr_i[16] ^ hdr_i[20] ^ hdr_i[21] ^
                   hdr_i[22] ^ hdr_i[23];
        ecc_o[1] = hdr_i[0]  ^ hdr_i[1]  ^ hdr_i[3]  ^ hdr_i[4]  ^ hdr_i[6]  ^ hdr_i[8]  ^
                   hdr_i[10] ^ hdr_i[12] ^ hdr_i[14] ^ hdr_i[17] ^ hdr_i[20] ^ hdr_i[21] ^
                   hdr_i[22] ^ hdr_i[23];
        ecc_o[2] = hdr_i[0]  ^ hdr_i[2]  ^ hdr_i[3]  ^ hdr_i[5]  ^ hdr_i[6]  ^ hdr_i[9]  ^
                   hdr_i[11] ^ hdr_i[12] ^ hdr_i[15] ^ hdr_i[18] ^ hdr_i[20] ^ hdr_i[21] ^
                   hdr_i[22];
        ecc_o[3] = hdr_i[1]  ^ hdr_i[2]  ^ hdr_i[3]  ^ hdr_i[7]  ^ hdr_i[8]  ^ hdr_i[9]  ^
                   hdr_i[13] ^ hdr_i[14] ^ hdr_i[15] ^ hdr_i[19] ^ hdr_i[20] ^ hdr_i[21] ^
                   hdr_i[23];
        ecc_o[4] = hdr_i[4]  ^ hdr_i[5]  ^ hdr_i[6]  ^ hdr_i[7]  ^ hdr_i[8]  ^ hdr_i[9]  ^
                   hdr_i[16] ^ hdr_i[17] ^ hdr_i[18] ^ hdr_i[19] ^ hdr_i[20] ^ hdr_i[22] ^
                   hdr_i[23];
        ecc_o[5] = hdr_i[10] ^ hdr_i[11] ^ hdr_i[12] ^ hdr_i[13] ^ hdr_i[14] ^ hdr_i[15] ^
                   hdr_i[16] ^ hdr_i[17] ^ hdr_i[18] ^ hdr_i[19] ^ hdr_i[21] ^ hdr_i[22] ^
                   hdr_i[23];
    end

endmodule

// File: rtl/mipi_rx_packet_controller.sv
// CSI-2 packet reception sequencer behind the lane aligner: parses the packet
// header, walks long-packet payload/CRC, emits byte-enabled payload words and
// frame/line event pulses, and raises packet_done_o to end HS reception.
// Build option: define MIPI_RX_ECC_CHECK_EN to enable header ECC checking.
//
// Stream semantics: lane_valid_i is a valid-only qualifier with no ready path.
// A word is consumed on every clock edge where lane_valid_i is 1; the
// controller never stalls the stream. payload_valid_o is likewise a one-cycle
// strobe the consumer must accept. All outputs are registered, one cycle
// after the input word that produced them.
import mipi_csi_pkg::*;

module mipi_rx_packet_controller #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TIMEOUT_W      = 12
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        lane_valid_i,
    input  logic [31:0] lane_byte_i,
    output logic        packet_done_o,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [3:0]  payload_be_o,
    output logic [5:0]  data_type_o,
    output logic [1:0]  virtual_channel_o,
    output logic [15:0] word_count_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic        truncated_o,
    output logic        timeout_o,
    output logic        ecc_error_o
);

    // FSM and counters
    rx_state_e             state_q, state_d;
    logic [16:0]           rem_q, rem_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

    // Registered outputs
    logic        packet_done_q, packet_done_d;
    logic        payload_valid_q, payload_valid_d;
    logic [31:0] payload_q, payload_d;
    logic [3:0]  payload_be_q, payload_be_d;
    logic [5:0]  data_type_q, data_type_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic        fs_q, fs_d;
    logic        fe_q, fe_d;
    logic        ls_q, ls_d;
    logic        le_q, le_d;
    logic        trunc_q, trunc_d;
    logic        tmo_q, tmo_d;
    logic        ecc_err_q, ecc_err_d;

    // Header fields of the incoming word
    logic [5:0]  hdr_dt;
    logic [1:0]  hdr_vc;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        hdr_ok;
    logic        tmo_hit;
    logic [16:0] pay_left;

    assign hdr_dt   = lane_byte_i[HDR_DI_LSB +: 6];
    assign hdr_vc   = lane_byte_i[HDR_DI_LSB + 6 +: 2];
    assign hdr_wc   = lane_byte_i[HDR_WC_LSB +: 16];
    assign hdr_long = (hdr_dt > DT_SHORT_MAX);
    assign tmo_hit  = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    // Payload bytes still owed before this word; only meaningful when rem_q > CRC_BYTES.
    assign pay_left = rem_q - CRC_BYTES;

`ifdef MIPI_RX_ECC_CHECK_EN
    logic [5:0] ecc_calc;

    mipi_csi_header_ecc u_header_ecc (
        .hdr_i (lane_byte_i[23:0]),
        .ecc_o (ecc_calc)
    );

    // Header accepted only if the ECC matches and the two spare bits are clear.
    assign hdr_ok = (lane_byte_i[HDR_ECC_LSB +: 6] == ecc_calc) &&
                    (lane_byte_i[HDR_ECC_LSB + 6 +: 2] == 2'b00);
`else
    // Without the checker every header is trusted, which holds ecc_error_o at 0.
    logic unused_hdr_ecc;
    assign hdr_ok         = 1'b1;
    assign unused_hdr_ecc = ^lane_byte_i[HDR_ECC_LSB +: 8];
`endif

    // State register: FSM, counters and every registered output.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            rem_q           <= '0;
            cnt_q           <= '0;
            packet_done_q   <= 1'b0;
            payload_valid_q <= 1'b0;
            payload_q       <= '0;
            payload_be_q    <= '0;
            data_type_q     <= '0;
            vc_q            <= '0;
            wc_q            <= '0;
            fs_q            <= 1'b0;
            fe_q            <= 1'b0;
            ls_q            <= 1'b0;
            le_q            <= 1'b0;
            trunc_q         <= 1'b0;
            tmo_q           <= 1'b0;
            ecc_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            cnt_q           <= cnt_d;
            packet_done_q   <= packet_done_d;
            payload_valid_q <= payload_valid_d;
            payload_q       <= payload_d;
            payload_be_q    <= payload_be_d;
            data_type_q     <= data_type_d;
            vc_q            <= vc_d;
            wc_q            <= wc_d;
            fs_q            <= fs_d;
            fe_q            <= fe_d;
            ls_q            <= ls_d;
            le_q            <= le_d;
            trunc_q         <= trunc_d;
            tmo_q           <= tmo_d;
            ecc_err_q       <= ecc_err_d;
        end
    end

    // Next-state logic: header decode, payload/CRC countdown, DONE timeout.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (lane_valid_i) begin
                    if (hdr_ok && hdr_long) begin
                        state_d = ST_PAYLOAD;
                        rem_d   = {1'b0, hdr_wc} + CRC_BYTES;
                    end else begin
                        // Short packet, or a corrupt header we refuse to follow.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i) begin
                    state_d = ST_IDLE;
                end else if (rem_q <= 17'd4) begin
                    state_d = ST_DONE;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - 17'd4;
                end
            end
            ST_DONE: begin
                if (!lane_valid_i || tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        packet_done_d   = (state_d == ST_DONE);
        payload_valid_d = 1'b0;
        payload_d       = '0;
        payload_be_d    = '0;
        data_type_d     = data_type_q;
        vc_d            = vc_q;
        wc_d            = wc_q;
        fs_d            = 1'b0;
        fe_d            = 1'b0;
        ls_d            = 1'b0;
        le_d            = 1'b0;
        trunc_d         = 1'b0;
        tmo_d           = 1'b0;
        ecc_err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lane_valid_i) begin
                    if (!hdr_ok) begin
                        ecc_err_d = 1'b1;
                    end else begin
                        data_type_d = hdr_dt;
                        vc_d        = hdr_vc;
                        wc_d        = hdr_wc;
                        if (!hdr_long) begin
                            fs_d = (hdr_dt == DT_FRAME_START);
                            fe_d = (hdr_dt == DT_FRAME_END);
                            ls_d = (hdr_dt == DT_LINE_START);
                            le_d = (hdr_dt == DT_LINE_END);
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i) begin
                    trunc_d = 1'b1;
                end else if (rem_q > CRC_BYTES) begin
                    payload_valid_d = 1'b1;
                    payload_d       = lane_byte_i;
                    payload_be_d    = (pay_left >= 17'd4) ? 4'hF : tail_be(pay_left[1:0]);
                end
            end
            ST_DONE: begin
                tmo_d = lane_valid_i && tmo_hit;
            end
            default: begin
            end
        endcase
    end

    assign packet_done_o     = packet_done_q;
    assign payload_valid_o   = payload_valid_q;
    assign payload_o         = payload_q;
    assign payload_be_o      = payload_be_q;
    assign data_type_o       = data_type_q;
    assign virtual_channel_o = vc_q;
    assign word_count_o      = wc_q;
    assign frame_start_o     = fs_q;
    assign frame_end_o       = fe_q;
    assign line_start_o      = ls_q;
    assign line_end_o        = le_q;
    assign truncated_o       = trunc_q;
    assign timeout_o         = tmo_q;
    assign ecc_error_o       = ecc_err_q;

endmodule

// File: tb/tb_mipi_rx_packet_controller.sv
// Directed bench for mipi_rx_packet_controller. Each step drives one input
// word, queues the output vector expected one cycle later and compares it.
// Header ECC cases are included when MIPI_RX_ECC_CHECK_EN is defined.
module tb_mipi_rx_packet_controller;

  localparam int TMO   = 4095;
  localparam int OBS_W = 69;

  // clock / reset
  logic        clk_i;
  logic        reset_i;
  logic        lane_valid_i;
  logic [31:0] lane_byte_i;
  logic        packet_done_o;
  logic        payload_valid_o;
  logic [31:0] payload_o;
  logic [3:0]  payload_be_o;
  logic [5:0]  data_type_o;
  logic [1:0]  virtual_channel_o;
  logic [15:0] word_count_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic        truncated_o;
  logic        timeout_o;
  logic        ecc_error_o;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  mipi_rx_packet_controller #(
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (12)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .lane_valid_i      (lane_valid_i),
    .lane_byte_i       (lane_byte_i),
    .packet_done_o     (packet_done_o),
    .payload_valid_o   (payload_valid_o),
    .payload_o         (payload_o),
    .payload_be_o      (payload_be_o),
    .data_type_o       (data_type_o),
    .virtual_channel_o (virtual_channel_o),
    .word_count_o      (word_count_o),
    .frame_start_o     (frame_start_o),
    .frame_end_o       (frame_end_o),
    .line_start_o      (line_start_o),
    .line_end_o        (line_end_o),
    .truncated_o       (truncated_o),
    .timeout_o         (timeout_o),
    .ecc_error_o       (ecc_error_o)
  );

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  int               vectors;
  int               miscompares;
  logic [5:0]       cur_dt;
  logic [1:0]       cur_vc;
  logic [15:0]      cur_wc;

  function automatic logic [OBS_W-1:0] obs();
    return {packet_done_o, payload_valid_o, payload_o, payload_be_o, data_type_o,
            virtual_channel_o, word_count_o, frame_start_o, frame_end_o,
            line_start_o, line_end_o, truncated_o, timeout_o, ecc_error_o};
  endfunction

  // ev = {frame_start, frame_end, line_start, line_end}
  function automatic logic [OBS_W-1:0] mk(input logic done, input logic pv,
                                          input logic [31:0] pay, input logic [3:0] be,
                                          input logic [3:0] ev, input logic tr,
                                          input logic to, input logic ee);
    return {done, pv, pay, be, cur_dt, cur_vc, cur_wc, ev, tr, to, ee};
  endfunction

  function automatic logic [OBS_W-1:0] idle();
    return mk(1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [5:0] ecc6(input logic [23:0] h);
    logic [5:0] e;
    e[0] = ^(h & 24'hF12CB7);
    e[1] = ^(h & 24'hF2555B);
    e[2] = ^(h & 24'h749A6D);
    e[3] = ^(h & 24'hB8E38E);
    e[4] = ^(h & 24'hDF03F0);
    e[5] = ^(h & 24'hEFFC00);
    return e;
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] h;
    h = {wc, di};
`ifdef MIPI_RX_ECC_CHECK_EN
    return {2'b00, ecc6(h), h};
`else
    return {8'hA5, h};
`endif
  endfunction

  function automatic logic [31:0] rnd32();
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = 8'($urandom_range(255, 0));
    return r;
  endfunction

  task automatic check(input string tag);
    logic [OBS_W-1:0] ex;
    logic [OBS_W-1:0] ob;
    ex = exp_q.pop_front();
    ob = obs();
    vectors++;
    assert (ob === ex) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, ob, ex);
    end
  endtask

  // driver: apply one word, expect e on the outputs one cycle later
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic [OBS_W-1:0] e);
    lane_valid_i = v;
    lane_byte_i  = d;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    check(tag);
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    vectors      = 0;
    miscompares  = 0;
    cur_dt       = '0;
    cur_vc       = '0;
    cur_wc       = '0;
    reset_i      = 1'b1;
    lane_valid_i = 1'b0;
    lane_byte_i  = '0;

    // reset state, even with a header present
    step("reset_0", 1'b0, 32'h0, idle());
    step("reset_1", 1'b1, hdr(8'h00, 16'h0001), idle());
    reset_i = 1'b0;
    step("idle_novalid", 1'b0, 32'hFFFF_FFFF, idle());

    // short frame start
    cur_dt = 6'h00; cur_vc = 2'd0; cur_wc = 16'h0001;
    step("fs_hdr", 1'b1, hdr(8'h00, 16'h0001), mk(1, 0, 0, 0, 4'b1000, 0, 0, 0));
    step("fs_drop", 1'b0, 32'h0, idle());
    step("fs_idle", 1'b0, 32'h0, idle());

    // long DT 0x2B, WC=5: full word then one byte plus CRC
    cur_dt = 6'h2B; cur_wc = 16'd5;
    step("l5_hdr", 1'b1, hdr(8'h2B, 16'd5), idle());
    step("l5_w0", 1'b1, 32'h4433_2211, mk(0, 1, 32'h4433_2211, 4'hF, 0, 0, 0, 0));
    step("l5_w1", 1'b1, 32'hC2C1_0055, mk(1, 1, 32'hC2C1_0055, 4'h1, 0, 0, 0, 0));
    step("l5_drop", 1'b0, 32'h0, idle());

    // long WC=0, VC=1: CRC-only word
    cur_dt = 6'h12; cur_vc = 2'd1; cur_wc = 16'd0;
    step("l0_hdr", 1'b1, hdr(8'h52, 16'd0), idle());
    step("l0_crc", 1'b1, 32'h0000_BEEF, mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("l0_drop", 1'b0, 32'h0, idle());

    // long WC=6: tail BE=3
    cur_dt = 6'h2A; cur_vc = 2'd0; cur_wc = 16'd6;
    r0 = rnd32(); r1 = rnd32();
    step("l6_hdr", 1'b1, hdr(8'h2A, 16'd6), idle());
    step("l6_w0", 1'b1, r0, mk(0, 1, r0, 4'hF, 0, 0, 0, 0));
    step("l6_w1", 1'b1, r1, mk(1, 1, r1, 4'h3, 0, 0, 0, 0));
    step("l6_drop", 1'b0, 32'h0, idle());

    // long WC=7: tail BE=7 then a word holding only the last CRC byte
    cur_dt = 6'h24; cur_vc = 2'd2; cur_wc = 16'd7;
    r0 = rnd32(); r1 = rnd32(); r2 = rnd32();
    step("l7_hdr", 1'b1, hdr(8'hA4, 16'd7), idle());
    step("l7_w0", 1'b1, r0, mk(0, 1, r0, 4'hF, 0, 0, 0, 0));
    step("l7_w1", 1'b1, r1, mk(0, 1, r1, 4'h7, 0, 0, 0, 0));
    step("l7_w2", 1'b1, r2, mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("l7_drop", 1'b0, 32'h0, idle());

    // long WC=4: exact full word, CRC in its own word
    cur_dt = 6'h2A; cur_vc = 2'd0; cur_wc = 16'd4;
    r0 = rnd32();
    step("l4_hdr", 1'b1, hdr(8'h2A, 16'd4), idle());
    step("l4_w0", 1'b1, r0, mk(0, 1, r0, 4'hF, 0, 0, 0, 0));
    step("l4_crc", 1'b1, 32'h0000_1234, mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("l4_drop", 1'b0, 32'h0, idle());

    // truncation: WC=16 but valid falls after two words
    cur_dt = 6'h30; cur_wc = 16'd16;
    r0 = rnd32(); r1 = rnd32();
    step("tr_hdr", 1'b1, hdr(8'h30, 16'd16), idle());
    step("tr_w0", 1'b1, r0, mk(0, 1, r0, 4'hF, 0, 0, 0, 0));
    step("tr_w1", 1'b1, r1, mk(0, 1, r1, 4'hF, 0, 0, 0, 0));
    step("tr_drop", 1'b0, 32'h0, mk(0, 0, 0, 0, 0, 1, 0, 0));

    // next header accepted straight after truncation; DONE ignores further words
    cur_dt = 6'h02; cur_vc = 2'd3; cur_wc = 16'h1234;
    step("ls_hdr", 1'b1, hdr(8'hC2, 16'h1234), mk(1, 0, 0, 0, 4'b0010, 0, 0, 0));
    step("ls_ignore", 1'b1, hdr(8'h00, 16'h0001), mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("ls_drop", 1'b0, 32'h0, idle());

    cur_dt = 6'h03; cur_vc = 2'd0; cur_wc = 16'h0007;
    step("le_hdr", 1'b1, hdr(8'h03, 16'h0007), mk(1, 0, 0, 0, 4'b0001, 0, 0, 0));
    step("le_drop", 1'b0, 32'h0, idle());

    cur_dt = 6'h01; cur_vc = 2'd0; cur_wc = 16'h0002;
    step("fe_hdr", 1'b1, hdr(8'h01, 16'h0002), mk(1, 0, 0, 0, 4'b0100, 0, 0, 0));
    step("fe_drop", 1'b0, 32'h0, idle());

    // timeout: silent short DT 0x08, valid held high in DONE
    cur_dt = 6'h08; cur_vc = 2'd0; cur_wc = 16'hABCD;
    step("tmo_hdr", 1'b1, hdr(8'h08, 16'hABCD), mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int j = 1; j < TMO; j++) begin
      step("tmo_wait", 1'b1, rnd32(), mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    step("tmo_fire", 1'b1, rnd32(), mk(0, 0, 0, 0, 0, 0, 1, 0));
    step("tmo_idle", 1'b0, 32'h0, idle());

    // reset in the middle of a payload clears everything, no pulses
    cur_dt = 6'h2B; cur_wc = 16'd16;
    r0 = rnd32();
    step("rm_hdr", 1'b1, hdr(8'h2B, 16'd16), idle());
    step("rm_w0", 1'b1, r0, mk(0, 1, r0, 4'hF, 0, 0, 0, 0));
    reset_i = 1'b1;
    cur_dt = '0; cur_vc = '0; cur_wc = '0;
    step("rm_reset", 1'b1, rnd32(), idle());
    reset_i = 1'b0;
    step("rm_after", 1'b0, 32'h0, idle());
    cur_dt = 6'h00; cur_wc = 16'h0003;
    step("rm_fs_hdr", 1'b1, hdr(8'h00, 16'h0003), mk(1, 0, 0, 0, 4'b1000, 0, 0, 0));
    step("rm_fs_drop", 1'b0, 32'h0, idle());

`ifdef MIPI_RX_ECC_CHECK_EN
    // correct frame end header
    cur_dt = 6'h01; cur_vc = 2'd0; cur_wc = 16'h0000;
    step("ecc_fe_ok", 1'b1, hdr(8'h01, 16'h0000), mk(1, 0, 0, 0, 4'b0100, 0, 0, 0));
    step("ecc_fe_drop", 1'b0, 32'h0, idle());
    // one flipped WC bit: error pulse, no event, header fields keep old values
    step("ecc_bad_wc", 1'b1, hdr(8'h01, 16'h0000) ^ 32'h0000_0100, mk(1, 0, 0, 0, 0, 0, 0, 1));
    step("ecc_bad_drop", 1'b0, 32'h0, idle());
    // spare ECC bits must be zero
    step("ecc_bad_top", 1'b1, hdr(8'h02, 16'h0000) ^ 32'h4000_0000, mk(1, 0, 0, 0, 0, 0, 0, 1));
    step("ecc_top_drop", 1'b0, 32'h0, idle());
    // long header with ECC error must not enter payload
    step("ecc_bad_long", 1'b1, hdr(8'h2B, 16'd8) ^ 32'h0010_0000, mk(1, 0, 0, 0, 0, 0, 0, 1));
    step("ecc_long_hold", 1'b1, rnd32(), mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("ecc_long_drop", 1'b0, 32'h0, idle());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
